mux16_rr_sched: RTL and testbench
=================================

MUX16_RR_SCHED -- requirements
Module: mux16_rr_sched

Interface
REQ-001 SHALL have parameter BURST_LEN, default 4: maximum consecutive transfers per grant before rotation; legal range 1..15.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req, input, 16: per-channel request; bit k is channel k.
REQ-005 SHALL have port din, input, 16: per-channel data bit; din[k] is data input ik of the 16:1 mux.
REQ-006 SHALL have port out_ready, input, 1: downstream ready.
REQ-007 SHALL have port out_valid, output, 1: out_data is valid for channel sel.
REQ-008 SHALL have port out_data, output, 1: din[sel] through the 16:1 mux, combinational from din.
REQ-009 SHALL have port sel, output, 4: registered mux select {s3,s2,s1,s0}.
REQ-010 SHALL have port grant, output, 16: one-hot of sel while out_valid=1; otherwise 0.

Function
REQ-011 SHALL implement the two states IDLE and XFER.
REQ-012 In IDLE with req!=0, the block SHALL pick the first set req bit at or after ptr, ascending with wrap 15->0. It SHALL load sel and enter XFER; out_valid rises one cycle after the req edge.
REQ-013 In IDLE with req==0, the block SHALL hold IDLE with out_valid=0 and sel unchanged.
REQ-014 A transfer SHALL occur on any cycle with out_valid=1 and out_ready=1; beat_cnt then increments.
REQ-015 While out_valid=1 and out_ready=0, sel and out_valid SHALL hold stable even if req[sel] drops.
REQ-016 On a transfer, the grant ends if beat_cnt+1==BURST_LEN or req[sel]==0 at that edge. Otherwise sel holds and XFER continues.
REQ-017 When a grant ends, ptr SHALL become (sel+1) mod 16 and beat_cnt SHALL become 0.
REQ-018 When a grant ends and another request is pending, the next pick SHALL be made in the same cycle using the new ptr, with no idle bubble. Otherwise the block SHALL go to IDLE.
REQ-019 A single requester holding req continuously SHALL be re-granted after each burst boundary, with no bubble.
REQ-020 Changes to req bits other than req[sel] during XFER SHALL not affect the current grant.
REQ-021 Worst-case wait for an asserted request SHALL be 15*BURST_LEN transfers.

Reset
REQ-022 While rst_n=0, the block SHALL force state=IDLE, ptr=0, beat_cnt=0, sel=0, out_valid=0 and grant=0, asynchronously.
REQ-023 Reset asserted mid-burst SHALL abort the burst with no transfer completed. After release, arbitration SHALL restart from channel 0.
REQ-024 out_data SHALL equal din[0] while in reset.

Configuration
REQ-025 Macro MUX16_RR_SCHED_PERF_EN, when defined, SHALL add output xfer_cnt[15:0].
REQ-026 xfer_cnt SHALL count completed transfers, saturate at 16'hFFFF, and reset to 0.
REQ-027 With MUX16_RR_SCHED_PERF_EN undefined, the xfer_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Package mux16_sched_pkg SHALL hold NUM_CH=16, SEL_W=4, the state enum (IDLE, XFER) and the beat counter width.
REQ-029 The round-robin picker SHALL be sub-module mux16_rr_pick: inputs req[15:0] and ptr[3:0]; outputs found and idx[3:0]; purely combinational.
REQ-030 out_data SHALL come from the team's existing 4:1-stage 16:1 mux, driven by sel.

Verification
REQ-031 Scenario: req=16'h0000 after reset -> out_valid=0, sel=0 for 20 cycles.
REQ-032 Scenario: req=16'h8001, out_ready=1, BURST_LEN=4 -> 4 beats on sel=0, then 4 beats on sel=15, then 4 on sel=0; no bubble cycles.
REQ-033 Scenario: req=16'h0004, din=16'h0004, out_ready=0 for 5 cycles -> out_valid=1, sel=2, out_data=1, grant=16'h0004 held stable; one transfer on the first out_ready=1.
REQ-034 Scenario: req=16'h0020 dropped to 0 while stalled -> grant held until handshake; then IDLE with ptr=6.
REQ-035 Scenario: ptr=15 (after a grant of channel 14) and req=16'h4001 -> next sel=0, showing the 15->0 wrap.
REQ-036 Scenario: rst_n pulsed low mid-burst on sel=9 -> out_valid=0 within the same cycle; after release with req=16'h0200, sel=9 is granted from ptr=0; xfer_cnt (when PERF_EN is defined) reads 0.

Source files
------------

// File: rtl/mux16_sched_pkg.sv
// Shared definitions for the 16-channel round-robin mux scheduler:
// channel count, select width, FSM state encoding, beat-counter width
// and a one-hot decode helper.
package mux16_sched_pkg;

   localparam int NUM_CH = 16;
   localparam int SEL_W  = 4;
   localparam int BEAT_W = 4;   // holds 0..14, enough for BURST_LEN up to 15

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } state_t;

   // One-hot decode of a channel index
   function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] s);
      logic [NUM_CH-1:0] v;
      v    = '0;
      v[s] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/mux16_rr_pick.sv
// Combinational round-robin picker: finds the first set request bit at or
// after ptr, searching upward and wrapping from channel 15 to channel 0.
module mux16_rr_pick
   import mux16_sched_pkg::*;
(
   input  logic [NUM_CH-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   output logic              found,
   output logic [SEL_W-1:0]  idx
);

   // Priority scan starting at ptr; the 4-bit add gives the 15->0 wrap for free
   always_comb begin
      logic [SEL_W-1:0] k;
      // NOTE: every output gets a default before the loop so no path leaves it
      // unassigned, which would otherwise infer a latch.
      found = 1'b0;
      idx   = '0;
      k     = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         k = ptr + SEL_W'(i);
         if (!found && req[k]) begin
            found = 1'b1;
            idx   = k;
         end
      end
   end

endmodule

// File: rtl/mux16_tree.sv
// 16:1 data mux built as two stages of 4:1 muxes: sel[1:0] picks within
// each group of four inputs, sel[3:2] picks among the four groups.
module mux16_tree
   import mux16_sched_pkg::*;
(
   input  logic [NUM_CH-1:0] din,
   input  logic [SEL_W-1:0]  sel,
   output logic              dout
);

   logic [3:0] stage1;

   function automatic logic mux4(input logic [3:0] d, input logic [1:0] s);
      return d[s];
   endfunction

   for (genvar g = 0; g < 4; g++) begin : g_stage1
      assign stage1[g] = mux4(din[4*g +: 4], sel[1:0]);
   end

   assign dout = mux4(stage1, sel[3:2]);

endmodule

// File: rtl/mux16_rr_sched.sv
// Round-robin scheduled 16:1 single-bit mux. A channel holds the grant for
// up to BURST_LEN transfers (out_valid & out_ready), then the pointer moves
// past it and the next requester is picked in the same cycle.
// Optional feature: define MUX16_RR_SCHED_PERF_EN to add the saturating
// transfer counter output xfer_cnt.
module mux16_rr_sched
   import mux16_sched_pkg::*;
#(
   parameter int BURST_LEN = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [15:0]       req,
   input  logic [15:0]       din,
   input  logic              out_ready,
   output logic              out_valid,
   output logic              out_data,
   output logic [3:0]        sel,
   output logic [15:0]       grant
`ifdef MUX16_RR_SCHED_PERF_EN
   ,
   output logic [15:0]       xfer_cnt
`endif
);

   if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
      $error("mux16_rr_sched: BURST_LEN must be in 1..15");
   end

   state_t            state;
   logic [SEL_W-1:0]  ptr;
   logic [BEAT_W-1:0] beat_cnt;

   logic              xfer;
   logic              grant_end;
   logic [SEL_W-1:0]  pick_ptr;
   logic              pick_found;
   logic [SEL_W-1:0]  pick_idx;

   assign xfer      = out_valid && out_ready;
   assign grant_end = (int'(beat_cnt) + 1 == BURST_LEN) || !req[sel];

   // In XFER the only pick that matters is the back-to-back one at grant end,
   // which must already use the advanced pointer (sel+1).
   assign pick_ptr = (state == XFER) ? sel + 4'd1 : ptr;

   mux16_rr_pick u_pick (
      .req   (req),
      .ptr   (pick_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   mux16_tree u_mux (
      .din  (din),
      .sel  (sel),
      .dout (out_data)
   );

   // Scheduler FSM with registered sel / out_valid / grant
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ptr       <= '0;
         beat_cnt  <= '0;
         sel       <= '0;
         out_valid <= 1'b0;
         grant     <= '0;
      end else begin
         // NOTE: all state here uses non-blocking assignments so every register
         // samples pre-edge values, independent of statement order.
         case (state)
            IDLE: begin
               if (pick_found) begin
                  sel       <= pick_idx;
                  grant     <= onehot(pick_idx);
                  out_valid <= 1'b1;
                  beat_cnt  <= '0;
                  state     <= XFER;
               end
            end

            XFER: begin
               // A stalled beat holds everything, even if req[sel] drops
               if (xfer) begin
                  if (grant_end) begin
                     ptr      <= sel + 4'd1;
                     beat_cnt <= '0;
                     if (pick_found) begin
                        sel   <= pick_idx;
                        grant <= onehot(pick_idx);
                     end else begin
                        out_valid <= 1'b0;
                        grant     <= '0;
                        state     <= IDLE;
                     end
                  end else begin
                     beat_cnt <= beat_cnt + 4'd1;
                  end
               end
            end

            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               grant     <= '0;
            end
         endcase
      end
   end

`ifdef MUX16_RR_SCHED_PERF_EN
   // Saturating count of completed transfers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xfer_cnt <= '0;
      end else if (xfer && xfer_cnt != 16'hFFFF) begin
         xfer_cnt <= xfer_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed self-checking bench for mux16_rr_sched (BURST_LEN = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_mux16_rr_sched;

   logic        clk;
   logic        rst_n;
   logic [15:0] req;
   logic [15:0] din;
   logic        out_ready;
   logic        out_valid;
   logic        out_data;
   logic [3:0]  sel;
   logic [15:0] grant;
`ifdef MUX16_RR_SCHED_PERF_EN
   logic [15:0] xfer_cnt;
`endif

   int n_total;
   int n_pass;

   mux16_rr_sched #(.BURST_LEN(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .din       (din),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sel       (sel),
      .grant     (grant)
`ifdef MUX16_RR_SCHED_PERF_EN
      ,
      .xfer_cnt  (xfer_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected select for the 0x8001 burst pattern: 4x ch0, 4x ch15, 4x ch0
   logic [3:0] exp_sel32 [12];

   initial begin
      n_total   = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      req       = 16'h0000;
      din       = 16'h0001;
      out_ready = 1'b0;
      exp_sel32 = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15, 4'd15, 4'd15,
                    4'd0, 4'd0, 4'd0, 4'd0};

      // Reset state; out_data follows din[0]
      tick();
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_sel",   32'(sel),       32'h0);
      check("rst_grant", 32'(grant),     32'h0);
      check("rst_data1", 32'(out_data),  32'h1);
      din = 16'hFFFE;
      #1;
      check("rst_data0", 32'(out_data),  32'h0);
`ifdef MUX16_RR_SCHED_PERF_EN
      check("rst_cnt",   32'(xfer_cnt),  32'h0);
`endif
      tick();
      rst_n = 1'b1;

      // No requests for 20 cycles: stays idle on sel 0
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_hold", {27'd0, out_valid, sel}, 32'h0);
      end

      // 0x8001 with ready: bursts of 4 alternate ch0/ch15 with no bubble
      req       = 16'h8001;
      out_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("rr_valid", 32'(out_valid), 32'h1);
         check("rr_sel",   32'(sel),       32'(exp_sel32[i]));
      end
      check("rr_grant0", 32'(grant), 32'h0001);
      req = 16'h0000;
      tick();
      check("rr_idle_valid", 32'(out_valid), 32'h0);
      check("rr_idle_grant", 32'(grant),     32'h0);

      // ch2 stalled for 5 cycles: outputs held; ptr is 1 here
      req       = 16'h0004;
      din       = 16'h0004;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", 32'(out_valid), 32'h1);
         check("stall_sel",   32'(sel),       32'h2);
         check("stall_data",  32'(out_data),  32'h1);
         check("stall_grant", 32'(grant),     32'h0004);
      end
      out_ready = 1'b1;
      tick();
      check("stall_beat1_sel", 32'(sel), 32'h2);
      req = 16'h0000;
      tick();
      check("stall_end_valid", 32'(out_valid), 32'h0);

      // ch5 drops its request while stalled: grant held until handshake
      req       = 16'h0020;
      out_ready = 1'b0;
      tick();
      check("drop_sel", 32'(sel), 32'h5);
      req = 16'h0000;
      for (int i = 0; i < 2; i++) begin
         tick();
         check("drop_valid", 32'(out_valid), 32'h1);
         check("drop_grant", 32'(grant),     32'h0020);
      end
      out_ready = 1'b1;
      tick();
      check("drop_idle_valid", 32'(out_valid), 32'h0);
      check("drop_idle_grant", 32'(grant),     32'h0);
      // ptr must now be 6: with ch0 and ch6 requesting, ch6 wins
      req       = 16'h0041;
      out_ready = 1'b0;
      tick();
      check("ptr6_sel", 32'(sel), 32'h6);

      // Release ch6, then grant ch14 for a full burst; ptr 15 wraps to ch0
      req       = 16'h0000;
      out_ready = 1'b1;
      tick();
      check("wrap_idle", 32'(out_valid), 32'h0);
      req       = 16'h4000;
      out_ready = 1'b0;
      tick();
      check("wrap_sel14", 32'(sel), 32'hE);
      req       = 16'h4001;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("wrap_hold14", 32'(sel), 32'hE);
      end
      tick();
      check("wrap_sel0",   32'(sel),       32'h0);
      check("wrap_valid",  32'(out_valid), 32'h1);
      check("wrap_grant",  32'(grant),     32'h0001);
`ifdef MUX16_RR_SCHED_PERF_EN
      check("perf_cnt",    32'(xfer_cnt),  32'd20);
`endif

      // Move to ch9, reset mid-burst, then re-arbitrate from ptr 0
      req = 16'h0200;
      tick();
      check("mid_sel9", 32'(sel), 32'h9);
      tick();
      check("mid_sel9b", 32'(sel), 32'h9);
      #2;
      rst_n = 1'b0;
      din   = 16'h0201;
      #1;
      check("arst_valid", 32'(out_valid), 32'h0);
      check("arst_sel",   32'(sel),       32'h0);
      check("arst_grant", 32'(grant),     32'h0);
      check("arst_data",  32'(out_data),  32'h1);
`ifdef MUX16_RR_SCHED_PERF_EN
      check("arst_cnt",   32'(xfer_cnt),  32'h0);
`endif
      tick();
      check("arst_hold", 32'(out_valid), 32'h0);
      rst_n = 1'b1;
      tick();
      check("post_valid", 32'(out_valid), 32'h1);
      check("post_sel",   32'(sel),       32'h9);
      check("post_grant", 32'(grant),     32'h0200);
      check("post_data",  32'(out_data),  32'h1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
